// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward controller for the 5-stage pipeline
// Includes divide sequencing, data-memory wait states and exception redirect.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic       jrD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic       regwriteE,
  input  logic       memtoregE,
  input  logic       divE,
  input  logic [4:0] writeregM,
  input  logic       regwriteM,
  input  logic       memtoregM,
  input  logic       memaccessM,
  input  logic       dmem_ready,
  input  logic       imem_ready,
  input  logic [4:0] writeregW,
  input  logic       regwriteW,
  input  logic       exc_M,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       div_start,
  output logic       div_abort,
  output logic       div_busy,
  output logic       pc_redirect
);

  typedef enum logic {IDLE, DIV} state_t;

  localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 1);

  state_t     state, stateNext;
  logic [5:0] cnt, cntNext;
  logic       memStall, startDiv, busy, lwStall, brStall;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic regMatch(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwdSel(input logic [4:0] src);
    if (regwriteM && regMatch(writeregM, src))
      return 2'b10;
    else if (regwriteW && regMatch(writeregW, src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign memStall = memaccessM && !dmem_ready;
  assign startDiv = (state == IDLE) && divE && !exc_M && !memStall;
  assign busy     = startDiv || ((state == DIV) && (cnt != 6'd0));

  assign lwStall = memtoregE && (regMatch(writeregE, rsD) || regMatch(writeregE, rtD));
  assign brStall = (branchD || jrD) &&
                   ((regwriteE && (regMatch(writeregE, rsD) || regMatch(writeregE, rtD))) ||
                    (memtoregM && (regMatch(writeregM, rsD) || regMatch(writeregM, rtD))));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (exc_M) begin
      stateNext = IDLE;
      cntNext   = 6'd0;
    end else if (!memStall) begin
      case (state)
        IDLE: begin
          if (divE) begin
            stateNext = DIV;
            cntNext   = CNT_INIT;
          end
        end
        DIV: begin
          // The completing divide leaves E this cycle; divE here is that same divide.
          if (cnt == 6'd0)
            stateNext = IDLE;
          else
            cntNext = cnt - 6'd1;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    flushM      = 1'b0;
    flushW      = 1'b0;
    forwardAD   = 1'b0;
    forwardBD   = 1'b0;
    forwardAE   = 2'b00;
    forwardBE   = 2'b00;
    div_start   = 1'b0;
    div_abort   = 1'b0;
    div_busy    = 1'b0;
    pc_redirect = 1'b0;
    if (reset) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      forwardAD = regwriteM && regMatch(writeregM, rsD);
      forwardBD = regwriteM && regMatch(writeregM, rtD);
      forwardAE = fwdSel(rsE);
      forwardBE = fwdSel(rtE);
      div_start = startDiv;
      div_busy  = busy;
      if (exc_M) begin
        flushD      = 1'b1;
        flushE      = 1'b1;
        flushM      = 1'b1;
        flushW      = 1'b1;
        pc_redirect = 1'b1;
        div_abort   = (state == DIV);
      end else if (memStall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (busy) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (lwStall || brStall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end else if (!imem_ready) begin
        stallF = 1'b1;
        flushD = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized check of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int DIVC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, jrD, regwriteE, memtoregE, divE;
  logic       regwriteM, memtoregM, memaccessM, dmem_ready, imem_ready;
  logic       regwriteW, exc_M;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       div_start, div_abort, div_busy, pc_redirect;

  int nCompared   = 0;
  int nMismatched = 0;
  // Position of the divide in E: -1 none, 0 start cycle, DIVC the completing cycle.
  int divPos = -1;

  logic [8:0] obsCtl;
  logic [5:0] obsFwd;
  logic [2:0] obsDiv;

  pipe_hazard_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .divE(divE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .memaccessM(memaccessM), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .writeregW(writeregW), .regwriteW(regwriteW), .exc_M(exc_M),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .div_start(div_start), .div_abort(div_abort), .div_busy(div_busy),
    .pc_redirect(pc_redirect)
  );

  always #5 clk = ~clk;

  function automatic bit hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] refFwd(input logic [4:0] src);
    if (regwriteM && hit(writeregM, src)) return 2'b10;
    if (regwriteW && hit(writeregW, src)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control vector order: stallF stallD stallE stallM flushD flushE flushM flushW pc_redirect
  task automatic refOut(output logic [8:0] eCtl, output logic [5:0] eFwd, output logic [2:0] eDiv);
    bit memStall, start, busy, hazard, srcD;
    if (reset) begin
      eCtl = 9'b0000_1111_0;
      eFwd = 6'd0;
      eDiv = 3'd0;
    end else begin
      eFwd = {regwriteM && hit(writeregM, rsD), regwriteM && hit(writeregM, rtD),
              refFwd(rsE), refFwd(rtE)};
      memStall = memaccessM && !dmem_ready;
      start    = (divPos < 0) && divE && !exc_M && !memStall;
      busy     = start || (divPos >= 1 && divPos < DIVC);
      srcD     = 0;
      hazard   = memtoregE && (hit(writeregE, rsD) || hit(writeregE, rtD));
      if (branchD || jrD)
        srcD = (regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
               (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD)));
      hazard = hazard || srcD;
      eDiv = {start, exc_M && (divPos >= 1), busy};
      if (exc_M)          eCtl = 9'b0000_1111_1;
      else if (memStall)  eCtl = 9'b1111_0001_0;
      else if (busy)      eCtl = 9'b1110_0010_0;
      else if (hazard)    eCtl = 9'b1100_0100_0;
      else if (!imem_ready) eCtl = 9'b1000_1000_0;
      else                eCtl = 9'b0;
    end
  endtask

  task automatic step(input string tag);
    logic [8:0] eCtl;
    logic [5:0] eFwd;
    logic [2:0] eDiv;
    #2;
    if (reset) divPos = -1;
    refOut(eCtl, eFwd, eDiv);
    obsCtl = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, pc_redirect};
    obsFwd = {forwardAD, forwardBD, forwardAE, forwardBE};
    obsDiv = {div_start, div_abort, div_busy};
    chk({tag, "_ctl"}, 32'(obsCtl), 32'(eCtl));
    chk({tag, "_fwd"}, 32'(obsFwd), 32'(eFwd));
    chk({tag, "_div"}, 32'(obsDiv), 32'(eDiv));
    @(posedge clk);
    if (reset) divPos = -1;
    else if (exc_M) divPos = -1;
    else if (!(memaccessM && !dmem_ready)) begin
      if (divPos < 0) begin
        if (divE) divPos = 1;
      end else if (divPos == DIVC) divPos = -1;
      else divPos++;
    end
    @(negedge clk);
  endtask

  task automatic clr();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {branchD, jrD, regwriteE, memtoregE, divE, regwriteM, memtoregM} = '0;
    {memaccessM, regwriteW, exc_M} = '0;
    dmem_ready = 1'b1;
    imem_ready = 1'b1;
  endtask

  initial begin
    int busyCnt, startCnt, guard;
    logic sawAbort;
    reset = 1'b1;
    clr();
    @(negedge clk);
    step("reset0");
    step("reset1");
    reset = 1'b0;
    step("idle");

    memtoregE = 1; writeregE = 5'd8; rsD = 5'd8;
    step("lwstall");
    chk("lwstall_bits", 32'(obsCtl), 32'(9'b1100_0100_0));
    rsD = 5'd0; writeregE = 5'd0;
    step("lw_zero");
    clr();

    regwriteM = 1; writeregM = 5'd5; rsE = 5'd5; regwriteW = 1; writeregW = 5'd5;
    step("fwd_mw");
    chk("fwdAE_M", 32'(obsFwd[3:2]), 32'd2);
    regwriteM = 0;
    step("fwd_w");
    chk("fwdAE_W", 32'(obsFwd[3:2]), 32'd1);
    clr();

    busyCnt = 0; startCnt = 0;
    divE = 1;
    for (int i = 0; i < 5; i++) begin
      step("div");
      busyCnt  += int'(obsDiv[0]);
      startCnt += int'(obsDiv[2]);
    end
    divE = 0;
    step("div_done");
    busyCnt  += int'(obsDiv[0]);
    startCnt += int'(obsDiv[2]);
    chk("div_busy_cycles", 32'(busyCnt), 32'd4);
    chk("div_start_pulses", 32'(startCnt), 32'd1);

    divE = 1;
    step("exc_start");
    exc_M = 1;
    step("exc");
    sawAbort = obsDiv[1];
    chk("exc_abort", 32'(sawAbort), 32'd1);
    exc_M = 0; divE = 0;
    step("exc_after");
    chk("exc_idle", 32'(obsDiv), 32'd0);

    divE = 1;
    step("ms_start");
    busyCnt = 1;
    memaccessM = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("ms_wait");
      busyCnt += int'(obsDiv[0]);
    end
    memaccessM = 0; dmem_ready = 1;
    guard = 0;
    do begin
      step("ms_run");
      busyCnt += int'(obsDiv[0]);
      guard++;
    end while (obsDiv[0] && guard < 20);
    chk("ms_guard", 32'(guard < 20), 32'd1);
    chk("ms_busy_cycles", 32'(busyCnt), 32'd7);
    divE = 0;
    step("ms_idle");

    divE = 1;
    step("rst_start");
    step("rst_busy");
    reset = 1;
    step("rst_mid");
    chk("rst_mid_ctl", 32'(obsCtl), 32'(9'b0000_1111_0));
    reset = 0; divE = 0; imem_ready = 0;
    step("rst_imem");
    chk("rst_imem_ctl", 32'(obsCtl), 32'(9'b1000_1000_0));
    clr();

    for (int i = 0; i < 400; i++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      branchD = 1'($urandom_range(0, 3) == 0); jrD = 1'($urandom_range(0, 7) == 0);
      regwriteE = 1'($urandom); memtoregE = 1'($urandom_range(0, 3) == 0);
      regwriteM = 1'($urandom); memtoregM = 1'($urandom_range(0, 3) == 0);
      regwriteW = 1'($urandom);
      divE = 1'($urandom_range(0, 4) == 0);
      exc_M = 1'($urandom_range(0, 29) == 0);
      memaccessM = 1'($urandom_range(0, 2) == 0);
      dmem_ready = 1'($urandom_range(0, 4) < 3);
      imem_ready = 1'($urandom_range(0, 4) != 0);
      reset = 1'($urandom_range(0, 99) == 0);
      step("rand");
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
